// File: rtl/t_demux_1x10_loader.sv
// Stream-to-ten-slot loader feeding the 10:1 display mux.
// Define DEMUX_DOUBLE_BUF_EN for shadow slots with a one-cycle atomic commit; default writes y directly.
`timescale 1ns/1ps
module t_demux_1x10_loader #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_addr_en,
  input  logic [3:0]        in_addr,
  input  logic              in_last,
  input  logic              frame_start,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [DATA_W-1:0] y4,
  output logic [DATA_W-1:0] y5,
  output logic [DATA_W-1:0] y6,
  output logic [DATA_W-1:0] y7,
  output logic [DATA_W-1:0] y8,
  output logic [DATA_W-1:0] y9,
  output logic [3:0]        wr_ptr,
  output logic              frame_done,
  output logic              err_addr
);

  logic [DATA_W-1:0] y_q [10];
  logic              accept;
  logic              auto_mode;
  logic              addr_bad;
  logic              do_write;
  logic              trigger;
  logic [3:0]        auto_slot;
  logic [3:0]        wr_slot;
  logic [3:0]        wr_ptr_q;
  logic [3:0]        wr_ptr_nxt;

  // frame_start redirects a same-cycle auto beat to slot 0
  assign auto_mode = ~in_addr_en;
  assign auto_slot = frame_start ? 4'd0 : wr_ptr_q;
  assign addr_bad  = in_addr_en && (in_addr > 4'd9);
  assign wr_slot   = in_addr_en ? in_addr : auto_slot;
  assign accept    = in_valid && in_ready;
  assign do_write  = accept && !addr_bad;
  assign trigger   = accept && (in_last || (auto_mode && (auto_slot == 4'd9)));

  // An auto beat into slot 9 always triggers, so the increment never passes 9
  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    if (trigger)
      wr_ptr_nxt = 4'd0;
    else if (accept && auto_mode)
      wr_ptr_nxt = auto_slot + 4'd1;
    else if (frame_start)
      wr_ptr_nxt = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 4'd0;
      err_addr <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      err_addr <= accept && addr_bad;
    end
  end

`ifdef DEMUX_DOUBLE_BUF_EN
  typedef enum logic {FILL, COMMIT} state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [DATA_W-1:0] shadow_q [10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= FILL;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      FILL:    if (trigger) state_nxt = COMMIT;
      COMMIT:  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  assign in_ready = (state_q == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) shadow_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < 10; i++)
        if (do_write && (wr_slot == 4'(i))) shadow_q[i] <= in_data;
    end
  end

  // The whole frame moves to the outputs in the single COMMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) y_q[i] <= RESET_VAL;
      frame_done <= 1'b0;
    end else begin
      if (state_q == COMMIT)
        for (int i = 0; i < 10; i++) y_q[i] <= shadow_q[i];
      frame_done <= (state_q == COMMIT);
    end
  end
`else
  assign in_ready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) y_q[i] <= RESET_VAL;
      frame_done <= 1'b0;
    end else begin
      for (int i = 0; i < 10; i++)
        if (do_write && (wr_slot == 4'(i))) y_q[i] <= in_data;
      frame_done <= trigger;
    end
  end
`endif

  assign y0     = y_q[0];
  assign y1     = y_q[1];
  assign y2     = y_q[2];
  assign y3     = y_q[3];
  assign y4     = y_q[4];
  assign y5     = y_q[5];
  assign y6     = y_q[6];
  assign y7     = y_q[7];
  assign y8     = y_q[8];
  assign y9     = y_q[9];
  assign wr_ptr = wr_ptr_q;

endmodule

// File: tb/tb_t_demux_1x10_loader.sv
// Scoreboard bench for t_demux_1x10_loader; follows DEMUX_DOUBLE_BUF_EN so either build is modelled.
`timescale 1ns/1ps
module tb_t_demux_1x10_loader;

`ifdef DEMUX_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_addr_en = 1'b0;
  logic [3:0] in_addr = 4'd0;
  logic       in_last = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7, y8, y9;
  logic [3:0] wr_ptr;
  logic       frame_done;
  logic       err_addr;
  logic [79:0] y_obs;

  int n_total = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [79:0] y;
    logic [3:0]  ptr;
    logic        fd;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_y [10];
  logic [7:0] m_sh [10];
  logic [3:0] m_ptr;
  bit         m_commit;

  t_demux_1x10_loader #(.DATA_W(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_addr_en(in_addr_en), .in_addr(in_addr),
    .in_last(in_last), .frame_start(frame_start),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .y8(y8), .y9(y9), .wr_ptr(wr_ptr), .frame_done(frame_done), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  assign y_obs = {y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};

  task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_total++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 10; i++) begin
      m_y[i]  = 8'h00;
      m_sh[i] = 8'h00;
    end
    m_ptr    = 4'd0;
    m_commit = 1'b0;
  endtask

  // Predicts the outputs visible after the coming rising edge
  task automatic modelStep(input bit v, input logic [7:0] d, input bit ae,
                           input logic [3:0] a, input bit l, input bit fs);
    bit         rdy, acc, bad, trig;
    logic [3:0] slot;
    exp_t       e;
    rdy  = DB ? !m_commit : 1'b1;
    acc  = v && rdy;
    slot = ae ? a : (fs ? 4'd0 : m_ptr);
    bad  = ae && (a >= 4'd10);
    trig = acc && (l || (!ae && slot == 4'd9));
    e.fd  = DB ? m_commit : trig;
    e.err = acc && bad;
    if (DB && m_commit)
      for (int i = 0; i < 10; i++) m_y[i] = m_sh[i];
    if (acc && !bad) begin
      if (DB) m_sh[slot] = d;
      else    m_y[slot]  = d;
    end
    if (fs) m_ptr = 4'd0;
    if (acc && !ae) m_ptr = (slot == 4'd9) ? 4'd0 : slot + 4'd1;
    if (trig) m_ptr = 4'd0;
    m_commit = DB && trig;
    e.ptr = m_ptr;
    e.rdy = !m_commit;
    for (int i = 0; i < 10; i++) e.y[i*8 +: 8] = m_y[i];
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit ae,
                               input logic [3:0] a, input bit l, input bit fs);
    exp_t e;
    in_valid    = v;
    in_data     = d;
    in_addr_en  = ae;
    in_addr     = a;
    in_last     = l;
    frame_start = fs;
    modelStep(v, d, ae, a, l, fs);
    @(negedge clk);
    e = sb.pop_front();
    checkOutput("y", y_obs, e.y);
    checkOutput("wr_ptr", 80'(wr_ptr), 80'(e.ptr));
    checkOutput("frame_done", 80'(frame_done), 80'(e.fd));
    checkOutput("err_addr", 80'(err_addr), 80'(e.err));
    checkOutput("in_ready", 80'(in_ready), 80'(e.rdy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_y", y_obs, 80'h0);
    checkOutput("reset_wr_ptr", 80'(wr_ptr), 80'h0);
    checkOutput("reset_in_ready", 80'(in_ready), 80'h1);
    checkOutput("reset_frame_done", 80'(frame_done), 80'h0);

    // Full auto frame with in_valid held through the commit
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 4'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    idle(2);

    applyStimulus(1'b1, 8'hA5, 1'b1, 4'd4, 1'b1, 1'b0);
    idle(2);

    applyStimulus(1'b1, 8'h5C, 1'b1, 4'hC, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5F, 1'b1, 4'hF, 1'b0, 1'b0);
    idle(1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h88, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b1, 4'hB, 1'b1, 1'b0);
    idle(2);

    // Reset pulse while a commit is pending (or frame_done is high)
    applyStimulus(1'b1, 8'h42, 1'b1, 4'd2, 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #0.5;
    modelReset();
    checkOutput("async_rst_y", y_obs, 80'h0);
    checkOutput("async_rst_wr_ptr", 80'(wr_ptr), 80'h0);
    checkOutput("async_rst_frame_done", 80'(frame_done), 80'h0);
    checkOutput("async_rst_in_ready", 80'(in_ready), 80'h1);
    #0.5;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1, 4'(2 * i + 1), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCF, 1'b0, 4'd0, 1'b1, 1'b0);
    idle(1);

    for (int i = 0; i < 40; i++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
                    4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
